addsub_seq_n: RTL and testbench
===============================

ADDSUB_SEQ_N -- requirements
Module: addsub_seq_n

Interface
REQ-001 SHALL have parameter N, default 8: operand and result width in bits.
REQ-002 SHALL have parameter K, default 4: bits processed per cycle (chunk width); N SHALL be an integer multiple of K, with 1 <= K <= N.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit: operation request, sampled only when ready_o=1.
REQ-006 SHALL have port sub_i, input, 1 bit: operation select, 1=data0_i-data1_i, 0=data0_i+data1_i.
REQ-007 SHALL have port sign_i, input, 1 bit: overflow mode, 1=two's-complement signed, 0=unsigned.
REQ-008 SHALL have port data0_i, input, N bits: operand A.
REQ-009 SHALL have port data1_i, input, N bits: operand B.
REQ-010 SHALL have port ready_o, output, 1 bit: block can accept start_i this cycle.
REQ-011 SHALL have port done_o, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-012 SHALL have port data_o, output, N bits: result modulo 2^N.
REQ-013 SHALL have port over_o, output, 1 bit: overflow/borrow flag per REQ-022.
REQ-014 SHALL have port zero_o, output, 1 bit: data_o equals 0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on start_i=1; CALC->DONE after the last chunk; DONE->CALC on start_i=1, else DONE->IDLE.
REQ-016 SHALL drive ready_o=1 in IDLE and DONE, 0 in CALC.
REQ-017 SHALL, on the edge accepting start_i, latch data0_i, data1_i, sub_i, sign_i; later input changes SHALL not affect the operation in progress.
REQ-018 SHALL ignore start_i while in CALC (no restart, no queuing).
REQ-019 SHALL process chunk j (bits j*K..j*K+K-1, LSB chunk first) on the j-th CALC edge, using a registered carry between chunks; carry-in to chunk 0 = sub_i (1 for subtract), B inverted when subtracting.
REQ-020 SHALL take exactly N/K clock edges in CALC; done_o=1 for exactly the one cycle after the last chunk edge (state DONE), i.e. latency start-edge to done_o = N/K+1 cycles.
REQ-021 SHALL update data_o, over_o, zero_o only at the final chunk edge; they SHALL hold their values through DONE and IDLE until the next operation completes; intermediate chunk results SHALL not be visible on data_o.
REQ-022 SHALL set over_o: unsigned add = carry-out of MSB; unsigned sub = NOT carry-out of MSB (borrow, A<B); signed (add or sub) = MSB carry-in XOR MSB carry-out.
REQ-023 SHALL set zero_o=1 exactly when the final data_o equals 0, independent of over_o.
REQ-024 SHALL, when K=N, complete in one CALC edge with identical results.
REQ-025 SHALL accept a start_i in DONE as a back-to-back operation, with done_o still pulsing for the completed one in that cycle.

Reset
REQ-026 SHALL, while rst_i=1 at a clock edge, enter IDLE, clear chunk counter and carry register, and set data_o=0, over_o=0, zero_o=0, done_o=0, ready_o=1.
REQ-027 SHALL abort any operation in CALC when rst_i is asserted; no done_o pulse SHALL follow for the aborted operation.
REQ-028 SHALL give rst_i priority over start_i in the same cycle.

Verification
REQ-029 N=8,K=4, sub_i=1,sign_i=0, A=0x05,B=0x03 -> done_o 3 cycles after start edge, data_o=0x02, over_o=0, zero_o=0.
REQ-030 N=8,K=4, sub_i=1,sign_i=0, A=0x03,B=0x05 -> data_o=0xFE, over_o=1 (borrow); same with sign_i=1 -> data_o=0xFE, over_o=0.
REQ-031 N=8,K=4, sub_i=1,sign_i=1, A=0x80,B=0x01 -> data_o=0x7F, over_o=1; add A=0x7F,B=0x01 signed -> data_o=0x80, over_o=1.
REQ-032 N=8,K=4, sub_i=0,sign_i=0, A=0xFF,B=0x01 -> data_o=0x00, over_o=1, zero_o=1.
REQ-033 start A=0x10,B=0x01 sub; during CALC pulse start_i with A=0x00 and change inputs -> ignored, result 0x0F, single done_o pulse.
REQ-034 rst_i=1 for one cycle at 2nd CALC edge -> IDLE, ready_o=1, data_o=0, no done_o; subsequent start completes normally.

Source files
------------

// File: rtl/addsub_seq_n.sv
// rtl/addsub_seq_n.sv - chunk-serial N-bit adder/subtractor with overflow and zero flags
//
// Adds or subtracts two N-bit operands K bits per clock, least significant
// chunk first, carrying between chunks through a register.
//
// Ports:
//   clk_i    - clock, all state changes on the rising edge
//   rst_i    - synchronous active-high reset
//   start_i  - operation request, taken only while ready_o=1
//   sub_i    - 1: data0_i - data1_i, 0: data0_i + data1_i
//   sign_i   - 1: signed overflow, 0: unsigned carry/borrow
//   data0_i  - operand A
//   data1_i  - operand B
//   ready_o  - block can accept start_i this cycle
//   done_o   - one-cycle pulse, a new result is on data_o/over_o/zero_o
//   data_o   - result modulo 2^N
//   over_o   - overflow (signed) or carry/borrow (unsigned)
//   zero_o   - data_o equals 0

module addsub_seq_n #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic         sign_i,
  input  logic [N-1:0] data0_i,
  input  logic [N-1:0] data1_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [N-1:0] data_o,
  output logic         over_o,
  output logic         zero_o
);

  localparam int CHUNKS = N / K;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic          sub_q, sub_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  data_q, data_d;
  logic          over_q, over_d;
  logic          zero_q, zero_d;

  logic [K-1:0]  chunk_a;
  logic [K-1:0]  chunk_b;
  logic [K-1:0]  chunk_s;
  logic [K:0]    chunk_sum;
  logic          msb_cin;
  logic          msb_cout;
  logic          over_calc;
  logic [N-1:0]  res_full;

  // One chunk of the ripple add. b_q already holds ~B when subtracting and
  // carry_q starts at 1, so subtraction is A + ~B + 1.
  always_comb begin
    chunk_a   = a_q[cnt_q*K +: K];
    chunk_b   = b_q[cnt_q*K +: K];
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{K{1'b0}}, carry_q};
    chunk_s   = chunk_sum[K-1:0];
    msb_cout  = chunk_sum[K];
    // Carry into the top bit of a chunk recovered from that bit's sum:
    // s = a ^ b ^ cin  =>  cin = a ^ b ^ s. Only meaningful on the last chunk.
    msb_cin   = chunk_a[K-1] ^ chunk_b[K-1] ^ chunk_s[K-1];
    if (sign_q) begin
      over_calc = msb_cin ^ msb_cout;
    end else if (sub_q) begin
      over_calc = ~msb_cout;
    end else begin
      over_calc = msb_cout;
    end
    res_full                 = res_q;
    res_full[cnt_q*K +: K]   = chunk_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    sign_d  = sign_q;
    data_d  = data_q;
    over_d  = over_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = CALC;
          cnt_d   = '0;
          carry_d = sub_i;
          a_d     = data0_i;
          b_d     = sub_i ? ~data1_i : data1_i;
          res_d   = '0;
          sub_d   = sub_i;
          sign_d  = sign_i;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // Partial sums stay in res_q; data_o only moves on the final chunk.
        res_d   = res_full;
        carry_d = msb_cout;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          carry_d = 1'b0;
          data_d  = res_full;
          over_d  = over_calc;
          zero_d  = (res_full == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      sign_q  <= 1'b0;
      data_q  <= '0;
      over_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      over_q  <= over_d;
      zero_q  <= zero_d;
    end
  end

  assign ready_o = (state_q != CALC);
  assign done_o  = (state_q == DONE);
  assign data_o  = data_q;
  assign over_o  = over_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_addsub_seq_n.sv
// tb/tb_addsub_seq_n.sv - self-checking bench for addsub_seq_n (K=4 and K=N instances)

module tb_addsub_seq_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic       sign;
  logic [7:0] a;
  logic [7:0] b;

  logic       ready0, done0, over0, zero0;
  logic [7:0] data0;
  logic       ready1, done1, over1, zero1;
  logic [7:0] data1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_seq_n #(.N(8), .K(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .sign_i(sign),
    .data0_i(a), .data1_i(b), .ready_o(ready0), .done_o(done0),
    .data_o(data0), .over_o(over0), .zero_o(zero0)
  );

  addsub_seq_n #(.N(8), .K(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .sign_i(sign),
    .data0_i(a), .data1_i(b), .ready_o(ready1), .done_o(done1),
    .data_o(data1), .over_o(over1), .zero_o(zero1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic void compute(input bit s, input bit sg, input int x, input int y,
                                  output int r, output bit ov);
    int raw, sx, sy, sr;
    raw = s ? (x - y) : (x + y);
    r   = raw & 255;
    if (sg) begin
      sx = (x > 127) ? x - 256 : x;
      sy = (y > 127) ? y - 256 : y;
      sr = s ? (sx - sy) : (sx + sy);
      ov = (sr > 127) || (sr < -128);
    end else begin
      ov = s ? (x < y) : (raw > 255);
    end
  endfunction

  // Model: each instance is busy for lat[] edges after accepting a start.
  int  lat [2] = '{2, 1};
  bit  m_busy [2];
  int  m_left [2];
  bit  m_done [2];
  int  m_data [2];
  bit  m_over [2];
  bit  m_zero [2];
  int  p_data [2];
  bit  p_over [2];
  bit  mvalid = 1'b0;

  always @(posedge clk) begin : model
    bit acc;
    int r;
    bit o;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_data[i] = 0;
        m_over[i] = 1'b0;
        m_zero[i] = 1'b0;
      end else begin
        acc = !m_busy[i] && start;
        m_done[i] = 1'b0;
        if (m_busy[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
            m_data[i] = p_data[i];
            m_over[i] = p_over[i];
            m_zero[i] = (p_data[i] == 0);
          end
        end
        if (acc) begin
          compute(sub, sign, int'(a), int'(b), r, o);
          p_data[i] = r;
          p_over[i] = o;
          m_busy[i] = 1'b1;
          m_left[i] = lat[i];
        end
      end
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("ready0", ready0, !m_busy[0]);
      chk("done0",  done0,  m_done[0]);
      chk("data0",  data0,  m_data[0]);
      chk("over0",  over0,  m_over[0]);
      chk("zero0",  zero0,  m_zero[0]);
      chk("ready1", ready1, !m_busy[1]);
      chk("done1",  done1,  m_done[1]);
      chk("data1",  data1,  m_data[1]);
      chk("over1",  over1,  m_over[1]);
      chk("zero1",  zero1,  m_zero[1]);
    end
  end

  // Returns cycles counted from the cycle start_i was presented (that one = 1).
  task automatic wait_done(inout int c);
    while (done0 !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic run(input bit s, input bit sg, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] ed, input bit eo, input bit ez);
    int c;
    sub = s; sign = sg; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    wait_done(c);
    chk("lat", c, 3);
    chk("lit_data", data0, ed);
    chk("lit_over", over0, eo);
    chk("lit_zero", zero0, ez);
    @(negedge clk);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; sub = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready0, 1);
    chk("rst_done",  done0,  0);
    chk("rst_data",  data0,  0);
    chk("rst_over",  over0,  0);
    chk("rst_zero",  zero0,  0);
    // Reset wins over a simultaneous start.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_prio_ready", ready0, 1);
    rst = 1'b0;
    @(negedge clk);

    run(1, 0, 8'h05, 8'h03, 8'h02, 0, 0);
    run(1, 0, 8'h03, 8'h05, 8'hFE, 1, 0);
    run(1, 1, 8'h03, 8'h05, 8'hFE, 0, 0);
    run(1, 1, 8'h80, 8'h01, 8'h7F, 1, 0);
    run(0, 1, 8'h7F, 8'h01, 8'h80, 1, 0);
    run(0, 0, 8'hFF, 8'h01, 8'h00, 1, 1);
    run(0, 1, 8'h80, 8'h80, 8'h00, 1, 1);
    run(1, 0, 8'h00, 8'h00, 8'h00, 0, 1);
    run(0, 0, 8'h12, 8'h34, 8'h46, 0, 0);
    run(1, 1, 8'h7F, 8'hFF, 8'h80, 1, 0);

    // Start during CALC is ignored and inputs may change freely.
    sub = 1'b1; sign = 1'b0; a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'h07; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    c = 2;
    wait_done(c);
    chk("ign_lat",  c, 3);
    chk("ign_data", data0, 8'h0F);
    @(negedge clk);
    chk("ign_single_done", done0, 0);
    @(negedge clk);

    // Reset on the second CALC edge aborts the operation.
    sub = 1'b0; sign = 1'b0; a = 8'h21; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready0, 1);
    chk("abort_data",  data0,  0);
    chk("abort_done",  done0,  0);
    repeat (3) @(negedge clk);
    run(0, 0, 8'h21, 8'h11, 8'h32, 0, 0);

    // Back-to-back: new start presented in the DONE cycle.
    sub = 1'b0; sign = 1'b0; a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    wait_done(c);
    chk("b2b_lat1",  c, 3);
    chk("b2b_data1", data0, 8'h03);
    chk("b2b_ready", ready0, 1);
    sub = 1'b1; a = 8'h09; b = 8'h0A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    wait_done(c);
    chk("b2b_lat2",  c, 3);
    chk("b2b_data2", data0, 8'hFF);
    chk("b2b_over2", over0, 1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
